// File: rtl/seg_scan_pkg.sv
// Shared constants, state type and nibble helpers for the seven-segment scan sequencer.
package seg_scan_pkg;

    localparam int NUM_DIGITS = 4;
    localparam int SEL_W      = 2;
    localparam int NIB_W      = 4;
    localparam int WORD_W     = 16;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } scan_state_t;

    function automatic logic [NIB_W-1:0] nib_of(input logic [WORD_W-1:0] word,
                                                input logic [SEL_W-1:0]  idx);
        return word[idx*NIB_W +: NIB_W];
    endfunction

    // Index of the most-significant nonzero nibble; digit 0 when the word is all zero.
    function automatic logic [SEL_W-1:0] top_digit(input logic [WORD_W-1:0] word);
        logic [SEL_W-1:0] t;
        t = '0;
        for (int k = 1; k < NUM_DIGITS; k++) begin
            if (word[k*NIB_W +: NIB_W] != '0) t = SEL_W'(k);
        end
        return t;
    endfunction

endpackage

// File: rtl/scan_prescaler.sv
// Dwell prescaler: counts 0..DWELL-1 while run is high and flags the terminal count.
module scan_prescaler #(
    parameter int DWELL = 100000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic run,
    output logic tick
);

    localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DWELL - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        tick  = 1'b0;
        if (clr) begin
            cnt_d = '0;
        end else if (run) begin
            if (cnt_q == LAST) begin
                cnt_d = '0;
                tick  = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// 4-digit seven-segment scan sequencer with shadow word committed on frame boundaries.
// Optional leading-zero blanking is enabled by defining SEG_SCAN_LZ_BLANK_EN.
module seg_scan_ctrl
    import seg_scan_pkg::*;
#(
    parameter int DWELL = 100000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              load,
    input  logic [WORD_W-1:0] din,
    output logic [SEL_W-1:0]  sel,
    output logic [NIB_W-1:0]  nibble,
    output logic              digit_en,
    output logic              frame_tick,
    output logic              load_ack
);

    scan_state_t       state_q, state_d;
    logic [SEL_W-1:0]  sel_q, sel_d;
    logic [NIB_W-1:0]  nibble_q, nibble_d;
    logic              digit_en_q, digit_en_d;
    logic              frame_tick_q, frame_tick_d;
    logic              load_ack_q, load_ack_d;
    logic [WORD_W-1:0] active_q, active_d;
    logic [WORD_W-1:0] shadow_q, shadow_d;
    logic              pending_q, pending_d;

    logic run;
    logic tick;
    logic wrap;
    logic commit;

    assign run = (state_q == RUN) && en;

    scan_prescaler #(.DWELL(DWELL)) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .clr  (!run),
        .run  (run),
        .tick (tick)
    );

    // A waiting word (or one arriving now) lands on a frame wrap, or at once while idle.
    assign wrap   = run && tick && (sel_q == SEL_W'(NUM_DIGITS - 1));
    assign commit = (pending_q || load) && (wrap || (state_q == IDLE));

    always_comb begin
        state_d      = en ? RUN : IDLE;
        sel_d        = '0;
        active_d     = active_q;
        shadow_d     = shadow_q;
        pending_d    = pending_q;
        frame_tick_d = wrap;
        load_ack_d   = commit;

        if (run && tick) sel_d = sel_q + 1'b1;
        else if (run)    sel_d = sel_q;

        if (commit) begin
            active_d  = load ? din : shadow_q;
            pending_d = 1'b0;
        end else if (load) begin
            shadow_d  = din;
            pending_d = 1'b1;
        end

        nibble_d = nib_of(active_d, sel_d);
`ifdef SEG_SCAN_LZ_BLANK_EN
        digit_en_d = (state_d == RUN) && (sel_d <= top_digit(active_d));
`else
        digit_en_d = (state_d == RUN);
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            sel_q        <= '0;
            nibble_q     <= '0;
            digit_en_q   <= 1'b0;
            frame_tick_q <= 1'b0;
            load_ack_q   <= 1'b0;
            active_q     <= '0;
            shadow_q     <= '0;
            pending_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            sel_q        <= sel_d;
            nibble_q     <= nibble_d;
            digit_en_q   <= digit_en_d;
            frame_tick_q <= frame_tick_d;
            load_ack_q   <= load_ack_d;
            active_q     <= active_d;
            shadow_q     <= shadow_d;
            pending_q    <= pending_d;
        end
    end

    assign sel        = sel_q;
    assign nibble     = nibble_q;
    assign digit_en   = digit_en_q;
    assign frame_tick = frame_tick_q;
    assign load_ack   = load_ack_q;

endmodule
